// File: rtl/decode_logic.sv
// decode_logic: M6502 micro-operation decoder.
// Maps opcode and one-hot timing step to the datapath enable bus and keeps
// a sticky flag recording any undefined opcode seen at T0.
module decode_logic (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  timing,
  input  logic [7:0]  opcode,
  output logic [63:0] enables,
  output logic        illegal
);

  // Enable bit positions on the datapath bus
  localparam int unsigned PC_INC       = 0;
  localparam int unsigned TIMING_RESET = 1;
  localparam int unsigned WRITE_EN     = 2;
  localparam int unsigned RA_DATA_IN_Q = 3;

  // Opcodes with dedicated sequences
  localparam logic [7:0] OP_NOP     = 8'hEA;
  localparam logic [7:0] OP_LDA_IMM = 8'hA9;
  localparam logic [7:0] OP_STORE   = 8'h8D;

  // Timing steps
  localparam logic [7:0] T0 = 8'h01;
  localparam logic [7:0] T1 = 8'h02;
  localparam logic [7:0] T2 = 8'h04;

  // True when exactly one bit of the timing vector is set
  function automatic logic is_one_hot(input logic [7:0] t);
    is_one_hot = (t != 8'h00) && ((t & (t - 8'h01)) == 8'h00);
  endfunction

  // True for every opcode outside the implemented set
  function automatic logic is_undefined(input logic [7:0] op);
    case (op)
      OP_NOP, OP_LDA_IMM, OP_STORE: is_undefined = 1'b0;
      default:                      is_undefined = 1'b1;
    endcase
  endfunction

  logic [63:0] enables_s;
  logic        illegal_r;

  // Combinational decode: reset and corrupt timing override the opcode table;
  // any valid step past an opcode's last step falls back to a bare restart.
  always_comb begin
    enables_s = 64'h0;
    if (!reset) begin
      enables_s = 64'h0;
    end else if (!is_one_hot(timing)) begin
      enables_s[TIMING_RESET] = 1'b1;
    end else begin
      case (opcode)
        OP_NOP: begin
          case (timing)
            T0: begin
              enables_s[PC_INC]       = 1'b1;
              enables_s[TIMING_RESET] = 1'b1;
            end
            default: enables_s[TIMING_RESET] = 1'b1;
          endcase
        end
        OP_LDA_IMM: begin
          case (timing)
            T0: enables_s[PC_INC] = 1'b1;
            T1: begin
              enables_s[RA_DATA_IN_Q] = 1'b1;
              enables_s[PC_INC]       = 1'b1;
              enables_s[TIMING_RESET] = 1'b1;
            end
            default: enables_s[TIMING_RESET] = 1'b1;
          endcase
        end
        OP_STORE: begin
          // Write happens at T1 so it never coincides with the opcode refetch
          // (memory reads back 0 while writing).
          case (timing)
            T0: enables_s[PC_INC] = 1'b1;
            T1: begin
              enables_s[WRITE_EN] = 1'b1;
              enables_s[PC_INC]   = 1'b1;
            end
            T2: begin
              enables_s[PC_INC]       = 1'b1;
              enables_s[TIMING_RESET] = 1'b1;
            end
            default: enables_s[TIMING_RESET] = 1'b1;
          endcase
        end
        default: begin
          // Undefined opcodes execute as a one-cycle NOP
          case (timing)
            T0: begin
              enables_s[PC_INC]       = 1'b1;
              enables_s[TIMING_RESET] = 1'b1;
            end
            default: enables_s[TIMING_RESET] = 1'b1;
          endcase
        end
      endcase
    end
  end

  // Sticky undefined-opcode flag, set at T0 and cleared only by reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      illegal_r <= 1'b0;
    end else if ((timing == T0) && is_undefined(opcode)) begin
      illegal_r <= 1'b1;
    end else begin
      illegal_r <= illegal_r;
    end
  end

  assign enables = enables_s;
  assign illegal = illegal_r;

endmodule

// File: tb/tb_decode_logic.sv
// tb_decode_logic: directed-vector bench for decode_logic.
module tb_decode_logic;

  logic        clock;
  logic        reset;
  logic [7:0]  timing;
  logic [7:0]  opcode;
  logic [63:0] enables;
  logic        illegal;

  int vec_count_r;
  int miscompare_r;

  decode_logic dut (
    .clock   (clock),
    .reset   (reset),
    .timing  (timing),
    .opcode  (opcode),
    .enables (enables),
    .illegal (illegal)
  );

  // Free-running clock, 10 time-unit period
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Single comparison point: counts every check and reports a miscompare
  task automatic check_vec(input string tag, input logic [63:0] observed,
                           input logic [63:0] expected);
    vec_count_r = vec_count_r + 1;
    if (observed !== expected) begin
      miscompare_r = miscompare_r + 1;
      $display("FAIL %s: got 64'h%0h, expected 64'h%0h", tag, observed, expected);
    end
  endtask

  // Drive a vector away from the rising edge and check enables combinationally
  task automatic apply(input string tag, input logic [7:0] op, input logic [7:0] tim,
                       input logic [63:0] exp_en);
    @(negedge clock);
    opcode = op;
    timing = tim;
    #1;
    check_vec(tag, enables, exp_en);
  endtask

  typedef struct {
    string       tag;
    logic [7:0]  op;
    logic [7:0]  tim;
    logic [63:0] exp_en;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vec_count_r  = 0;
    miscompare_r = 0;
    reset  = 1'b0;
    opcode = 8'hA9;
    timing = 8'h02;

    // Reset held low: everything quiet even across clock edges
    #1;
    check_vec("rst_enables", enables, 64'h0);
    check_vec("rst_illegal", {63'h0, illegal}, 64'h0);
    @(posedge clock);
    #1;
    check_vec("rst_enables_edge", enables, 64'h0);

    // Release reset mid-cycle: decode becomes valid immediately
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_vec("rst_release_lda_t1", enables, 64'hB);

    vecs.push_back('{"nop_t0",   8'hEA, 8'h01, 64'h3});
    vecs.push_back('{"nop_t1",   8'hEA, 8'h02, 64'h2});
    vecs.push_back('{"nop_t7",   8'hEA, 8'h80, 64'h2});
    vecs.push_back('{"lda_t0",   8'hA9, 8'h01, 64'h1});
    vecs.push_back('{"lda_t1",   8'hA9, 8'h02, 64'hB});
    vecs.push_back('{"lda_t2",   8'hA9, 8'h04, 64'h2});
    vecs.push_back('{"lda_t7",   8'hA9, 8'h80, 64'h2});
    vecs.push_back('{"sta_t0",   8'h8D, 8'h01, 64'h1});
    vecs.push_back('{"sta_t1",   8'h8D, 8'h02, 64'h5});
    vecs.push_back('{"sta_t2",   8'h8D, 8'h04, 64'h3});
    vecs.push_back('{"sta_t3",   8'h8D, 8'h08, 64'h2});
    vecs.push_back('{"sta_t7",   8'h8D, 8'h80, 64'h2});
    vecs.push_back('{"tz_nop",   8'hEA, 8'h00, 64'h2});
    vecs.push_back('{"tz_sta",   8'h8D, 8'h00, 64'h2});
    vecs.push_back('{"t03_lda",  8'hA9, 8'h03, 64'h2});
    vecs.push_back('{"t03_nop",  8'hEA, 8'h03, 64'h2});
    vecs.push_back('{"tff_sta",  8'h8D, 8'hFF, 64'h2});
    vecs.push_back('{"undef_t1", 8'hFF, 8'h02, 64'h2});
    vecs.push_back('{"undef_tz", 8'h00, 8'h00, 64'h2});
    vecs.push_back('{"undef_t03",8'h12, 8'h03, 64'h2});

    foreach (vecs[i]) begin
      apply(vecs[i].tag, vecs[i].op, vecs[i].tim, vecs[i].exp_en);
    end

    // No undefined opcode has been seen at T0 yet
    @(posedge clock);
    #1;
    check_vec("illegal_still_clear", {63'h0, illegal}, 64'h0);

    // Undefined opcode at T0: NOP-like decode, flag only after the edge
    apply("undef_t0", 8'hFF, 8'h01, 64'h3);
    check_vec("illegal_before_edge", {63'h0, illegal}, 64'h0);
    @(posedge clock);
    #1;
    check_vec("illegal_set", {63'h0, illegal}, 64'h1);

    // Sticky across defined opcodes
    apply("nop_after_undef", 8'hEA, 8'h01, 64'h3);
    @(posedge clock);
    #1;
    check_vec("illegal_sticky", {63'h0, illegal}, 64'h1);

    // Reset pulse clears asynchronously, between clock edges
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check_vec("illegal_async_clr", {63'h0, illegal}, 64'h0);
    check_vec("rst_enables_again", enables, 64'h0);

    // Undefined opcode at T0 while reset is low must not set the flag
    opcode = 8'hFF;
    timing = 8'h01;
    @(posedge clock);
    #1;
    check_vec("illegal_held_in_rst", {63'h0, illegal}, 64'h0);
    check_vec("rst_enables_undef", enables, 64'h0);

    // Another undefined opcode after release sets it again
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_vec("undef2_t0", enables, 64'h3);
    @(posedge clock);
    #1;
    check_vec("illegal_set_again", {63'h0, illegal}, 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count_r, miscompare_r);
    $finish;
  end

endmodule
